uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Memory-mapped UART transmitter for the core's IO space: the transmit counterpart to the receive-side UART block that raises an interrupt on byte arrival. The CPU writes bytes to a data address; they queue in a small FIFO and are serialized on `tx` at 115200 bps, 8N1, from a 50 MHz clock. A status word is exported, and `int_req` is raised when the queue has fully drained.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200).
- `FIFO_DEPTH`, default 8: queue entries; legal values are 2, 4, 8.
- `TX_DATA_ADDR`, default 32'h0000_0408: write address that pushes a byte.
- `TX_STAT_ADDR`, default 32'h0000_0410: status address; any access clears `int_req` and `overflow`.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `access_addr`  in  32  bus address, sampled every cycle.
- `wr_en`  in  1  bus write strobe, one cycle per write.
- `wr_data`  in  32  write data; only `[7:0]` is used.
- `tx`  out  1  serial line; idles high.
- `tx_busy_flag`  out  1  high while a frame is on the line.
- `status`  out  8  `{tx_busy_flag, full, empty, overflow, count[3:0]}`; combinational from registers.
- `int_req`  out  1  level interrupt: the transmit queue has drained.

## Operation
- Reset values:
  - `tx` = 1, `tx_busy_flag` = 0, `int_req` = 0.
  - FIFO empty: count = 0, empty = 1, full = 0, `overflow` = 0.
  - FSM in IDLE; all counters 0.
- Push:
  - Condition: `wr_en` && `access_addr == TX_DATA_ADDR` && !full.
  - Effect: `wr_data[7:0]` is written at the write pointer.
  - Pointers wrap modulo FIFO_DEPTH.
- Full condition:
  - A push attempted while full drops the byte and sets `overflow` (sticky).
  - Full is evaluated before any pop in the same cycle, so push-when-full plus pop in one cycle still drops the byte.
- Push and pop in the same cycle with the FIFO not full: both take effect and count is unchanged.
- FSM states:
  - IDLE: `tx` = 1. If FIFO not empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. At the end: if FIFO not empty, pop and go directly to START (no idle gap); otherwise go to IDLE and set `int_req`.
- `tx_busy_flag` = 1 in START, DATA and STOP.
- `tx` is driven from a flop, so there is no combinational glitch.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- `int_req`:
  - Set when the STOP state completes with the FIFO empty.
  - Cleared by any cycle with `access_addr == TX_STAT_ADDR`, or by a successful push.
  - If set and clear occur in the same cycle, set wins.
- `overflow`: cleared by a `TX_STAT_ADDR` access. A new overflow in the same cycle wins over the clear.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronously); the queued bytes and the partial frame are discarded.

## Timing
- Latency from push to line:
  - Push accepted on cycle N; count updates at N+1.
  - IDLE sees not-empty and pops at edge N+1.
  - `tx` falls at N+2.
- Frame length: 10 × CLKS_PER_BIT = 4340 cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `status` reflects register state in the same cycle; a push is visible in `count` one cycle after `wr_en`.
- `int_req` rises one cycle after the final stop-bit cycle. It falls one cycle after the clearing access.

## Test plan
- Single byte: push 0x55 at cycle 0.
  - `tx` low from cycle 2 for 434 cycles.
  - Then bits 1,0,1,0,1,0,1,0, each 434 cycles.
  - Stop high; `tx_busy_flag` falls at cycle 4342.
- Burst: push 0xA5, 0x00, 0xFF on consecutive cycles.
  - Three frames with no gap, 13020 cycles total from the first start bit.
  - `int_req` rises once, after the third stop bit.
- Overflow: while the first frame is active, push 9 more bytes.
  - `count` saturates at 8 with `full` = 1, `overflow` = 1; the 9th byte is absent from the output.
  - Read `TX_STAT_ADDR`: `overflow` = 0.
- Interrupt handshake:
  - After drain, `int_req` = 1 and holds while other addresses are accessed.
  - Access 0x0000_0410: `int_req` = 0 on the next cycle.
  - Separately, a push while `int_req` = 1 also clears it.
- Reset mid-frame: assert `rst_n` = 0 during DATA bit 3 with 2 bytes queued.
  - `tx` = 1 and `status` = 8'b0010_0000 immediately.
  - After release, no frame is sent.
- Set/clear collision: a `TX_STAT_ADDR` access on the same cycle the final stop bit completes leaves `int_req` = 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped 8N1 UART transmitter with a small byte queue.
// Bytes written to TX_DATA_ADDR are queued and sent LSB first. A status word
// is exported, and int_req is raised once the queue has fully drained.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more bytes wait
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_DATA_ADDR = 32'h0000_0408,
  parameter logic [31:0] TX_STAT_ADDR = 32'h0000_0410
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] access_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        tx,
  output logic        tx_busy_flag,
  output logic [7:0]  status,
  output logic        int_req
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [3:0]    DEPTH_C   = 4'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          int_q, int_d;

  logic full, empty, push_req, push, pop, stat_hit, baud_done, int_set;
  logic unused_wr_hi;

  assign unused_wr_hi = ^wr_data[31:8];

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == 4'd0);
  assign push_req  = wr_en && (access_addr == TX_DATA_ADDR);
  // Full is judged on the registered count, so a same-cycle pop cannot rescue a push.
  assign push      = push_req && !full;
  assign stat_hit  = (access_addr == TX_STAT_ADDR);
  assign baud_done = (baud_q == BAUD_LAST);

  // Frame sequencing; tx_d is the line value for the next cycle so tx stays a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    int_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            int_set = 1'b1;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Queue pointers, occupancy and sticky flags; set wins over clear for both flags.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (push_req && full) overflow_d = 1'b1;
    else if (stat_hit)    overflow_d = 1'b0;
    int_d = int_q;
    if (int_set)              int_d = 1'b1;
    else if (stat_hit || push) int_d = 1'b0;
  end

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data[7:0];
  end

  // State registers; reset forces the line high immediately and discards the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      int_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      int_q      <= int_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy_flag = (state_q != S_IDLE);
  assign int_req      = int_q;
  assign status       = {tx_busy_flag, full, empty, overflow_q, count_q};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line monitor decodes every frame and compares it
// against a scoreboard of accepted bytes; hand sequences check exact timing.
module tb_uart_tx_fifo;

  localparam int CPB = 434;
  localparam logic [31:0] DATA_A = 32'h0000_0408;
  localparam logic [31:0] STAT_A = 32'h0000_0410;

  logic        clk;
  logic        rst_n;
  logic [31:0] access_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        tx;
  logic        tx_busy_flag;
  logic [7:0]  status;
  logic        int_req;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .access_addr(access_addr), .wr_en(wr_en),
    .wr_data(wr_data), .tx(tx), .tx_busy_flag(tx_busy_flag),
    .status(status), .int_req(int_req)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
    logic        acc;
    logic [7:0]  st;
    logic        irq;
  } vec_t;

  vec_t       vt [15];
  logic [7:0] sb_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         frames_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    access_addr = a;
    wr_en       = w;
    wr_data     = {24'h0, d};
  endtask

  task automatic idle_bus();
    bus(32'h0, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    bus(DATA_A, 1'b1, d);
    sb_q.push_back(d);
  endtask

  task automatic apply_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus(vt[i].addr, vt[i].we, vt[i].data);
      if (vt[i].acc) sb_q.push_back(vt[i].data);
      tick(1);
      chk($sformatf("vec%0d_status", i), status, vt[i].st);
      chk($sformatf("vec%0d_int", i), int_req, vt[i].irq);
    end
    idle_bus();
  endtask

  // Decodes frames by sampling each bit at its midpoint.
  task automatic monitor();
    int         cnt;
    int         k;
    logic [7:0] b;
    bit         act;
    act = 0; cnt = 0; b = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) act = 0;
      else if (!act) begin
        if (tx === 1'b0) begin act = 1; cnt = 0; end
      end else cnt++;
      if (act && rst_n && cnt > 0) begin
        if (cnt == CPB / 2) chk("start_bit", tx, 1'b0);
        else if (cnt > CPB / 2 && ((cnt - CPB / 2) % CPB) == 0) begin
          k = (cnt - CPB / 2) / CPB;
          if (k >= 1 && k <= 8) b[k-1] = tx;
          else if (k == 9) begin
            chk("stop_bit", tx, 1'b1);
            frames_seen++;
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame: got %0h expected none", b);
            end else chk("frame_byte", b, sb_q.pop_front());
            act = 0;
          end
        end
      end
    end
  endtask

  initial begin
    int rises;
    logic prev;
    int low_cnt;
    int busy_cnt;

    vt[0]  = '{32'h0000_0400, 1'b0, 8'h00, 1'b0, 8'h20, 1'b1};
    vt[1]  = '{DATA_A,        1'b0, 8'h77, 1'b0, 8'h20, 1'b1};
    vt[2]  = '{32'h0000_0404, 1'b1, 8'h12, 1'b0, 8'h20, 1'b1};
    vt[3]  = '{STAT_A,        1'b0, 8'h00, 1'b0, 8'h20, 1'b0};
    vt[4]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0};
    vt[5]  = '{DATA_A, 1'b1, 8'hE0, 1'b1, 8'h81, 1'b0};
    vt[6]  = '{DATA_A, 1'b1, 8'hE1, 1'b1, 8'h82, 1'b0};
    vt[7]  = '{DATA_A, 1'b1, 8'hE2, 1'b1, 8'h83, 1'b0};
    vt[8]  = '{DATA_A, 1'b1, 8'hE3, 1'b1, 8'h84, 1'b0};
    vt[9]  = '{DATA_A, 1'b1, 8'hE4, 1'b1, 8'h85, 1'b0};
    vt[10] = '{DATA_A, 1'b1, 8'hE5, 1'b1, 8'h86, 1'b0};
    vt[11] = '{DATA_A, 1'b1, 8'hE6, 1'b1, 8'h87, 1'b0};
    vt[12] = '{DATA_A, 1'b1, 8'hE7, 1'b1, 8'hC8, 1'b0};
    vt[13] = '{DATA_A, 1'b1, 8'hE8, 1'b0, 8'hD8, 1'b0};
    vt[14] = '{STAT_A, 1'b0, 8'h00, 1'b0, 8'hC8, 1'b0};

    rst_n = 1'b0;
    idle_bus();
    tick(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy_flag, 1'b0);
    chk("rst_int", int_req, 1'b0);
    chk("rst_status", status, 8'h20);
    rst_n = 1'b1;
    tick(2);
    fork monitor(); join_none

    // Single byte 0x55: push on cycle 0, start bit from cycle 2.
    push(8'h55);
    tick(1); idle_bus();
    chk("single_c1_status", status, 8'h01);
    chk("single_c1_tx", tx, 1'b1);
    tick(1);
    chk("single_c2_tx", tx, 1'b0);
    chk("single_c2_status", status, 8'hA0);
    tick(433);
    chk("single_c435_tx", tx, 1'b0);
    tick(1);
    chk("single_c436_tx", tx, 1'b1);
    tick(3905);
    chk("single_c4341_busy", tx_busy_flag, 1'b1);
    chk("single_c4341_int", int_req, 1'b0);
    tick(1);
    chk("single_c4342_busy", tx_busy_flag, 1'b0);
    chk("single_c4342_int", int_req, 1'b1);
    chk("single_c4342_tx", tx, 1'b1);

    // Interrupt handshake from the table.
    apply_vec(0, 4);

    // Burst of three back-to-back frames.
    push(8'hA5); tick(1);
    push(8'h00); tick(1);
    push(8'hFF); tick(1);
    idle_bus();
    chk("burst_c3_status", status, 8'h82);
    rises = 0;
    prev  = int_req;
    for (int c = 4; c <= 13022; c++) begin
      tick(1);
      if (int_req && !prev) rises++;
      prev = int_req;
      if (c == 13021) begin
        chk("burst_c13021_busy", tx_busy_flag, 1'b1);
        chk("burst_c13021_int", int_req, 1'b0);
      end
    end
    chk("burst_c13022_busy", tx_busy_flag, 1'b0);
    chk("burst_c13022_int", int_req, 1'b1);
    chk("burst_int_rises", rises, 1);

    // Push clears int_req; status access on the final stop cycle loses to the set.
    push(8'h3C);
    tick(1); idle_bus();
    chk("push_clears_int", int_req, 1'b0);
    tick(4340);
    bus(STAT_A, 1'b0, 8'h00);
    tick(1);
    chk("collision_int", int_req, 1'b1);
    chk("collision_busy", tx_busy_flag, 1'b0);
    tick(1);
    idle_bus();
    chk("stat_clears_int", int_req, 1'b0);

    // Overflow: first frame active, then nine pushes into an empty queue.
    push(8'hD0);
    tick(1); idle_bus();
    tick(1);
    chk("ovf_c2_busy", tx_busy_flag, 1'b1);
    apply_vec(5, 14);
    for (int i = 0; i < 45000 && !int_req; i++) tick(1);
    chk("drain_int", int_req, 1'b1);
    chk("drain_sb_empty", sb_q.size(), 0);

    // Reset during data bit 3 with two bytes queued.
    push(8'hC1); tick(1);
    push(8'hC2); tick(1);
    push(8'hC3); tick(1);
    idle_bus();
    chk("rst_mid_count", status[3:0], 4'd2);
    tick(1897);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_status", status, 8'h20);
    chk("rst_mid_int", int_req, 1'b0);
    tick(3);
    rst_n = 1'b1;
    low_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (tx !== 1'b1) low_cnt++;
      if (tx_busy_flag !== 1'b0) busy_cnt++;
    end
    chk("post_rst_tx_low_cycles", low_cnt, 0);
    chk("post_rst_busy_cycles", busy_cnt, 0);
    chk("post_rst_status", status, 8'h20);

    chk("frames_seen", frames_seen, 14);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
